// File: rtl/lsu_tlb_rdctl.sv
// Round-robin sequencer for diagnostic/ASI reads of the DTLB.
// Grants one thread, issues one array read, waits out the latency, then selects the read format.
module lsu_tlb_rdctl #(
    parameter int NTHR   = 4,
    parameter int IDX_W  = 6,
    parameter int RD_LAT = 2
) (
    input  logic                  rclk,
    input  logic                  rst,
    input  logic [NTHR-1:0]       req_vld,
    input  logic [2*NTHR-1:0]     req_type,
    input  logic [IDX_W*NTHR-1:0] req_idx,
    output logic [NTHR-1:0]       req_ack,
    input  logic                  tlb_busy,
    output logic                  tlb_rd_en,
    output logic [IDX_W-1:0]      tlb_rd_idx,
    output logic                  lsu_tlb_data_rd_vld_g,
    output logic                  lsu_tlb_csm_rd_vld_g,
    input  logic                  tte_tag_parity_error,
    input  logic                  tte_data_parity_error,
    output logic                  rsp_vld,
    output logic [1:0]            rsp_tid,
    output logic                  rsp_par_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SEL} state_t;

    state_t           state, state_nxt;
    logic [1:0]       rr_ptr;
    logic [1:0]       tid_q;
    logic [1:0]       type_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [2:0]       cnt;
    logic             grant_found;
    logic [1:0]       grant_tid;
    logic             do_grant;

    // First requester at or after the round-robin pointer.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_tid   = '0;
        for (int i = 0; i < NTHR; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NTHR) cand = cand - NTHR;
            if (!grant_found && req_vld[cand]) begin
                grant_found = 1'b1;
                grant_tid   = cand[1:0];
            end
        end
    end

    // Reset is folded in so the ack stays quiet while reset is held with requests pending.
    assign do_grant = (state == IDLE) && grant_found && !tlb_busy && !rst;

    always_comb begin
        req_ack = '0;
        if (do_grant) req_ack[grant_tid] = 1'b1;
    end

    always_comb begin
        state_nxt             = state;
        tlb_rd_en             = 1'b0;
        rsp_vld               = 1'b0;
        rsp_tid               = '0;
        rsp_par_err           = 1'b0;
        lsu_tlb_data_rd_vld_g = 1'b0;
        lsu_tlb_csm_rd_vld_g  = 1'b0;
        case (state)
            IDLE: begin
                if (do_grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!tlb_busy) begin
                    tlb_rd_en = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) state_nxt = SEL;
            end
            SEL: begin
                rsp_vld = 1'b1;
                rsp_tid = tid_q;
                case (type_q)
                    2'b01: begin
                        lsu_tlb_data_rd_vld_g = 1'b1;
                        rsp_par_err           = tte_data_parity_error;
                    end
                    2'b10: begin
                        lsu_tlb_csm_rd_vld_g = 1'b1;
                    end
                    default: begin
                        rsp_par_err = tte_tag_parity_error;
                    end
                endcase
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The read index is presented with the strobe and then held until the next read.
    assign tlb_rd_idx = tlb_rd_en ? idx_q : rd_idx_q;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tid_q    <= '0;
            type_q   <= '0;
            idx_q    <= '0;
            rd_idx_q <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (do_grant) begin
                tid_q  <= grant_tid;
                type_q <= req_type[grant_tid*2 +: 2];
                idx_q  <= req_idx[grant_tid*IDX_W +: IDX_W];
                rr_ptr <= (grant_tid == 2'(NTHR-1)) ? 2'd0 : grant_tid + 2'd1;
            end
            if (tlb_rd_en) begin
                rd_idx_q <= idx_q;
                cnt      <= 3'(RD_LAT-1);
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

endmodule
